// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the mdu_hilo multiply/divide unit.
// The accumulate op codes decode as mul/div ops only when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_acc(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || is_acc(op);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return is_mul(op) || is_div(op);
`else
    return (op == OP_MULT) || (op == OP_MULTU) || is_div(op);
`endif
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider step datapath: one quotient bit per step on unsigned magnitudes.
// A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dsr_q};
    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dsr_d = divisor_i;
    end else if (step_i) begin
      // bit WIDTH of diff is the borrow: set means the trial subtract failed
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning HI/LO; stalls the pipeline while iterating.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
//
// state | meaning
// IDLE  | waiting for a mul/div op; MTHI/MTLO handled here
// BUSY  | one radix-2 multiply or divide step per cycle
// DONE  | sign fix-up and {HI,LO} write at end of cycle
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  import mdu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept;
  logic               mt_wr;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] res;
  logic [WIDTH-1:0]   div_q, div_r;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign accept = (state_q == ST_IDLE) && start_i && is_muldiv(op_i) && !flush_i;
  assign mt_wr  = (state_q == ST_IDLE) && start_i && !flush_i &&
                  ((op_i == OP_MTHI) || (op_i == OP_MTLO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: begin
        if (flush_i)              state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = !rst && ((state_q == ST_BUSY) || accept);
    done_o = (state_q == ST_DONE);
  end

  always_comb begin
    a_neg = is_signed(op_i) && a_i[WIDTH-1];
    b_neg = is_signed(op_i) && b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .step_i     ((state_q == ST_BUSY) && is_div(op_q)),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quo_o      (div_q),
    .rem_o      (div_r)
  );

  always_comb begin
    op_d    = op_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    // shift-add: upper half accumulates the multiplicand, multiplier bits drain from the bottom
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_s  = neg_q ? -prod_q : prod_q;
    quo_s   = neg_q ? -div_q : div_q;
    rem_s   = rneg_q ? -div_r : div_r;
    res     = is_div(op_q) ? {rem_s, quo_s} : prod_s;
`ifdef MDU_MADD_EN
    if (is_acc(op_q)) begin
      res = is_sub(op_q) ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
    end
`endif

    if (accept) begin
      op_d    = op_i;
      cnt_d   = '0;
      neg_d   = a_neg ^ b_neg;
      rneg_d  = a_neg;
      mcand_d = a_mag;
      prod_d  = {{WIDTH{1'b0}}, b_mag};
    end

    if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (is_mul(op_q)) prod_d = {mul_sum, prod_q[WIDTH-1:1]};
    end

    if ((state_q == ST_DONE) && !flush_i) {hi_d, lo_d} = res;

    if (mt_wr) begin
      if (op_i == OP_MTHI) hi_d = a_i;
      else                 lo_d = a_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed corner cases plus random ops against a
// plain-arithmetic HI/LO model. Honours MDU_MADD_EN for the accumulate ops.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [3:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         flush_i;
  logic         busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;

  logic [W-1:0] m_hi, m_lo;
  int n_vec = 0;
  int n_err = 0;

  mdu_hilo #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_is_long(input logic [3:0] op);
    if (op <= 4'd3) return 1'b1;
`ifdef MDU_MADD_EN
    if (op >= 4'd6 && op <= 4'd9) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Architectural effect of one completed op on the HI/LO model
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    int ia, ib;
`ifdef MDU_MADD_EN
    logic [63:0] acc;
    acc = {m_hi, m_lo};
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  {m_hi, m_lo} = 64'(sa * sb);
      OP_MULTU: {m_hi, m_lo} = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 0) begin
          m_hi = a;
          m_lo = a[W-1] ? 32'd1 : 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = a;
          m_hi = 32'd0;
        end else begin
          ia = $signed(a);
          ib = $signed(b);
          m_lo = 32'(ia / ib);
          m_hi = 32'(ia % ib);
        end
      end
      OP_DIVU: begin
        if (b == 0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
`ifdef MDU_MADD_EN
      OP_MADD:  {m_hi, m_lo} = acc + 64'(sa * sb);
      OP_MADDU: {m_hi, m_lo} = acc + {32'd0, a} * {32'd0, b};
      OP_MSUB:  {m_hi, m_lo} = acc - 64'(sa * sb);
      OP_MSUBU: {m_hi, m_lo} = acc - {32'd0, a} * {32'd0, b};
`endif
      default: ;
    endcase
  endfunction

  // Multi-cycle op; flush_cyc = cycle (0 = start cycle) in which flush_i is raised, -1 for none
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int flush_cyc);
    int busy_cnt, exp_cnt;
    bit bsy, dn, ended, exp_dn;
    busy_cnt = 0;
    ended    = 1'b0;
    bsy      = 1'b0;
    dn       = 1'b0;
    start_i  = 1'b1;
    op_i     = op;
    a_i      = a;
    b_i      = b;
    for (int c = 0; c < W + 10; c++) begin
      @(negedge clk);
      if (c == flush_cyc) flush_i = 1'b1;
      #1;
      bsy = busy_o;
      dn  = done_o;
      if (bsy) busy_cnt++;
      @(posedge clk);
      #1;
      if (flush_i) begin
        flush_i = 1'b0;
        start_i = 1'b0;
      end
      if (!bsy) begin
        ended = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    chk_eq("op_ended", 64'(ended), 64'd1);
    if (flush_cyc == 0)                    exp_cnt = 0;
    else if (flush_cyc > 0 && flush_cyc <= W) exp_cnt = flush_cyc + 1;
    else                                   exp_cnt = W + 1;
    exp_dn = !(flush_cyc >= 0 && flush_cyc <= W);
    chk_eq($sformatf("busy_cycles op%0d", op), 64'(busy_cnt), 64'(exp_cnt));
    chk_eq($sformatf("done_pulse op%0d", op), 64'(dn), 64'(exp_dn));
    if (flush_cyc < 0) ref_op(op, a, b);
    chk_eq($sformatf("hi op%0d", op), 64'(hi_o), 64'(m_hi));
    chk_eq($sformatf("lo op%0d", op), 64'(lo_o), 64'(m_lo));
    @(negedge clk);
    chk_eq("idle_after_op", 64'(busy_o), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Single-cycle op (MTHI/MTLO or a code that must be ignored)
  task automatic run_simple(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(negedge clk);
    chk_eq($sformatf("no_stall op%0d", op), 64'(busy_o), 64'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    ref_op(op, a, b);
    chk_eq($sformatf("hi op%0d", op), 64'(hi_o), 64'(m_hi));
    chk_eq($sformatf("lo op%0d", op), 64'(lo_o), 64'(m_lo));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   r_op;
    logic [W-1:0] r_a, r_b;
    int           r_fl;

    rst     = 1'b1;
    start_i = 1'b1;
    op_i    = OP_MULT;
    a_i     = 32'd3;
    b_i     = 32'd5;
    flush_i = 1'b0;
    m_hi    = '0;
    m_lo    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_hi", 64'(hi_o), 64'd0);
    chk_eq("rst_lo", 64'(lo_o), 64'd0);
    chk_eq("rst_busy", 64'(busy_o), 64'd0);
    chk_eq("rst_done", 64'(done_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1);
    chk_eq("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
    chk_eq("mult_lo", 64'(lo_o), 64'hFFFF_FFEB);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk_eq("multu_hi", 64'(hi_o), 64'hFFFF_FFFE);
    chk_eq("multu_lo", 64'(lo_o), 64'h0000_0001);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    chk_eq("div_lo", 64'(lo_o), 64'hFFFF_FFFD);
    chk_eq("div_hi", 64'(hi_o), 64'hFFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk_eq("divmin_lo", 64'(lo_o), 64'h8000_0000);
    chk_eq("divmin_hi", 64'(hi_o), 64'd0);
    run_op(OP_DIVU, 32'd5, 32'd0, -1);
    chk_eq("divu0_lo", 64'(lo_o), 64'hFFFF_FFFF);
    chk_eq("divu0_hi", 64'(hi_o), 64'd5);

    run_simple(OP_MTHI, 32'h1234, 32'd0);
    run_simple(OP_MTLO, 32'h5678, 32'd0);
    chk_eq("mthi_val", 64'(hi_o), 64'h1234);
    chk_eq("mtlo_val", 64'(lo_o), 64'h5678);

    run_op(OP_DIVU, 32'd1000, 32'd3, 10);
    run_op(OP_MULTU, 32'd9, 32'd9, W + 1);
    run_op(OP_MULT, 32'd9, 32'd9, 0);
    chk_eq("flush_keep_hi", 64'(hi_o), 64'h1234);
    chk_eq("flush_keep_lo", 64'(lo_o), 64'h5678);

`ifdef MDU_MADD_EN
    run_simple(OP_MTHI, 32'd0, 32'd0);
    run_simple(OP_MTLO, 32'd10, 32'd0);
    run_op(OP_MADD, 32'd3, 32'd4, -1);
    chk_eq("madd_lo", 64'(lo_o), 64'd22);
    chk_eq("madd_hi", 64'(hi_o), 64'd0);
    run_simple(OP_MTHI, 32'd0, 32'd0);
    run_simple(OP_MTLO, 32'd0, 32'd0);
    run_op(OP_MSUBU, 32'd1, 32'd1, -1);
    chk_eq("msubu_hi", 64'(hi_o), 64'hFFFF_FFFF);
    chk_eq("msubu_lo", 64'(lo_o), 64'hFFFF_FFFF);
`else
    run_simple(OP_MADD, 32'd3, 32'd4);
    chk_eq("madd_off_hi", 64'(hi_o), 64'h1234);
    chk_eq("madd_off_lo", 64'(lo_o), 64'h5678);
`endif
    run_simple(4'hF, 32'hDEAD_BEEF, 32'd1);

    // reset in the middle of a divide
    start_i = 1'b1;
    op_i    = OP_DIV;
    a_i     = 32'd100;
    b_i     = 32'd7;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_eq("midrst_hi", 64'(hi_o), 64'd0);
    chk_eq("midrst_lo", 64'(lo_o), 64'd0);
    chk_eq("midrst_busy", 64'(busy_o), 64'd0);
    start_i = 1'b0;
    m_hi    = '0;
    m_lo    = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(OP_MULT, 32'd6, 32'hFFFF_FFFB, -1);
    chk_eq("post_rst_lo", 64'(lo_o), 64'hFFFF_FFE2);

    for (int i = 0; i < 60; i++) begin
      r_op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      r_a  = pick_operand();
      r_b  = pick_operand();
      r_fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W + 1)) : -1;
      if (ref_is_long(r_op)) run_op(r_op, r_a, r_b, r_fl);
      else                   run_simple(r_op, r_a, r_b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
